// File: rtl/clkfwd_gen_pkg.sv
// Shared types and defaults for the forwarded-clock generator.
// Channel FSM encoding and the post-reset divide ratio.
package clkfwd_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } chan_st_e;

  localparam int DIV_RST_DEF = 2;

endpackage

// File: rtl/clkfwd_gen_if.sv
// Control and DDR-pattern bus of the forwarded-clock generator.
// master drives run requests and divide ratios; slave returns the patterns.
interface clkfwd_gen_if #(
  parameter int CHANNELS = 4,
  parameter int DIVW     = 8
);
  logic [CHANNELS-1:0]      en;
  logic [CHANNELS*DIVW-1:0] div;
  logic                     load;
  logic                     busy;
  logic [CHANNELS-1:0]      running;
  logic [CHANNELS-1:0]      q_rise;
  logic [CHANNELS-1:0]      q_fall;
  logic [CHANNELS-1:0]      sync;

  modport master (output en, div, load, input busy, running, q_rise, q_fall, sync);
  modport slave  (input en, div, load, output busy, running, q_rise, q_fall, sync);
endinterface

// File: rtl/clkfwd_chan.sv
// One forwarded-clock channel: half-cycle phase counter, run/stop FSM, shadow divide ratio.
// Outputs are registered one cycle after the state they describe; start/stop/ratio act only at period boundaries.
module clkfwd_chan
  import clkfwd_gen_pkg::*;
#(
  parameter int DIVW    = 8,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic            load,
  output logic            pend,
  output logic            running,
  output logic            q_rise,
  output logic            q_fall,
  output logic            sync
);
  localparam int PW = DIVW + 1;

  chan_st_e        st_q, st_d;
  logic [PW-1:0]   p_q, p_d;
  logic [DIVW-1:0] n_q, n_d, shadow_q, shadow_d;
  logic            pend_q, pend_d;
  logic            rise_q, rise_d, fall_q, fall_d, sync_q, sync_d, run_q, run_d;

  logic [PW-1:0]   n2, p_inc;
  logic [DIVW-1:0] n_eff, n_next;
  logic            boundary;

  // p is always even, so p+2 never exceeds 2N and p+1 never wraps.
  assign n2       = {n_q, 1'b0};
  assign p_inc    = p_q + PW'(2);
  assign boundary = (p_inc >= n2);
  assign n_eff    = pend_q ? shadow_q : n_q;
  assign n_next   = load ? div : n_eff;

  always_comb begin
    st_d     = st_q;
    p_d      = p_q;
    n_d      = n_q;
    shadow_d = load ? div : shadow_q;
    pend_d   = pend_q | load;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    sync_d   = 1'b0;
    run_d    = 1'b0;
    if (st_q == ST_IDLE) begin
      p_d    = '0;
      n_d    = n_eff;
      pend_d = load;
      if (en && (n_eff != '0)) st_d = ST_RUN;
    end else begin
      run_d  = 1'b1;
      rise_d = (p_q < PW'(n_q));
      fall_d = ((p_q + PW'(1)) < PW'(n_q));
      sync_d = (p_q == '0);
      if (boundary) begin
        // Pending (or same-cycle) ratio takes over; N=0 parks the channel.
        p_d    = '0;
        n_d    = n_next;
        pend_d = 1'b0;
        st_d   = (en && (n_next != '0)) ? ST_RUN : ST_IDLE;
      end else begin
        p_d  = p_inc;
        st_d = en ? ST_RUN : ST_STOPPING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      p_q      <= '0;
      n_q      <= DIVW'(DIV_RST);
      shadow_q <= DIVW'(DIV_RST);
      pend_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sync_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      p_q      <= p_d;
      n_q      <= n_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sync_q   <= sync_d;
      run_q    <= run_d;
    end
  end

  assign pend    = pend_q;
  assign running = run_q;
  assign q_rise  = rise_q;
  assign q_fall  = fall_q;
  assign sync    = sync_q;

endmodule

// File: rtl/clkfwd_gen.sv
// Multi-channel forwarded-clock pattern generator feeding external DDR output cells.
// Per channel: registered rise/fall bits, divide ratio changes applied glitch-free at period boundaries.
module clkfwd_gen
  import clkfwd_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIVW     = 8,
  parameter int DIV_RST  = DIV_RST_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  clkfwd_gen_if.slave  bus
);
  logic [CHANNELS-1:0] pend;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clkfwd_chan #(
      .DIVW    (DIVW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en[i]),
      .div     (bus.div[i*DIVW +: DIVW]),
      .load    (bus.load),
      .pend    (pend[i]),
      .running (bus.running[i]),
      .q_rise  (bus.q_rise[i]),
      .q_fall  (bus.q_fall[i]),
      .sync    (bus.sync[i])
    );
  end

  assign bus.busy = |pend;

endmodule

// File: tb/tb_clkfwd_gen.sv
// Bench for clkfwd_gen: directed vector table on channel 0, then random traffic against a period-level model.
module tb_clkfwd_gen;
  localparam int CH = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clkfwd_gen_if #(.CHANNELS(CH), .DIVW(DW)) bus ();

  clkfwd_gen #(.CHANNELS(CH), .DIVW(DW), .DIV_RST(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: each channel is either idle or somewhere in cycle k of an N-cycle period.
  int m_n [CH];
  int m_sh[CH];
  int m_k [CH];
  bit m_run [CH];
  bit m_pend[CH];
  logic [CH-1:0] e_rise, e_fall, e_sync, e_run;
  logic          e_busy;

  typedef struct packed {
    logic       en;
    logic [7:0] div;
    logic       load;
    logic [4:0] exp;   // {rise, fall, sync, running, busy} for channel 0
  } vec_t;

  vec_t tbl[27];

  function automatic logic [16:0] dut_vec();
    return {bus.q_rise, bus.q_fall, bus.sync, bus.running, bus.busy};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_n[i] = 2; m_sh[i] = 2; m_k[i] = 0; m_run[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_update();
    int dv;
    int n_eff;
    for (int i = 0; i < CH; i++) begin
      dv = int'(bus.div[i*DW +: DW]);
      e_rise[i] = m_run[i] && (2 * m_k[i] < m_n[i]);
      e_fall[i] = m_run[i] && (2 * m_k[i] + 1 < m_n[i]);
      e_sync[i] = m_run[i] && (m_k[i] == 0);
      e_run[i]  = m_run[i];
      n_eff = m_pend[i] ? m_sh[i] : m_n[i];
      if (!m_run[i]) begin
        m_n[i] = n_eff; m_pend[i] = bus.load; m_k[i] = 0;
        m_run[i] = bus.en[i] && (n_eff != 0);
      end else if (m_k[i] == m_n[i] - 1) begin
        m_n[i] = bus.load ? dv : n_eff; m_pend[i] = 0; m_k[i] = 0;
        m_run[i] = bus.en[i] && (m_n[i] != 0);
      end else begin
        m_k[i]++;
        if (bus.load) m_pend[i] = 1;
      end
      if (bus.load) m_sh[i] = dv;
    end
    e_busy = 1'b0;
    for (int i = 0; i < CH; i++) e_busy |= m_pend[i];
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_update();
    #1;
    check(name, dut_vec(), {e_rise, e_fall, e_sync, e_run, e_busy});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = '0; bus.div = '0; bus.load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("reset_state", dut_vec(), 17'd0);
  endtask

  initial begin
    bus.en = '0; bus.div = '0; bus.load = 1'b0;
    tbl = '{
      '{1'b1, 8'd0, 1'b0, 5'b00000}, '{1'b1, 8'd0, 1'b0, 5'b11110},
      '{1'b1, 8'd0, 1'b0, 5'b00010}, '{1'b1, 8'd0, 1'b0, 5'b11110},
      '{1'b1, 8'd0, 1'b0, 5'b00010}, '{1'b1, 8'd3, 1'b1, 5'b11111},
      '{1'b1, 8'd0, 1'b0, 5'b00010}, '{1'b1, 8'd0, 1'b0, 5'b11110},
      '{1'b1, 8'd0, 1'b0, 5'b10010}, '{1'b1, 8'd0, 1'b0, 5'b00010},
      '{1'b1, 8'd0, 1'b0, 5'b11110}, '{1'b1, 8'd5, 1'b1, 5'b10011},
      '{1'b1, 8'd0, 1'b0, 5'b00010}, '{1'b1, 8'd0, 1'b0, 5'b11110},
      '{1'b0, 8'd0, 1'b0, 5'b11010}, '{1'b0, 8'd0, 1'b0, 5'b10010},
      '{1'b0, 8'd0, 1'b0, 5'b00010}, '{1'b0, 8'd0, 1'b0, 5'b00010},
      '{1'b0, 8'd0, 1'b0, 5'b00000}, '{1'b0, 8'd0, 1'b0, 5'b00000},
      '{1'b1, 8'd0, 1'b0, 5'b00000}, '{1'b1, 8'd0, 1'b0, 5'b11110},
      '{1'b0, 8'd0, 1'b0, 5'b11010}, '{1'b1, 8'd0, 1'b0, 5'b10010},
      '{1'b1, 8'd0, 1'b0, 5'b00010}, '{1'b1, 8'd0, 1'b0, 5'b00010},
      '{1'b1, 8'd0, 1'b0, 5'b11110}
    };

    do_reset();

    // Directed: start at N=2, reload to 3 and 5, stop and restart on channel 0.
    for (int r = 0; r < 27; r++) begin
      bus.en   = {3'b000, tbl[r].en};
      bus.div  = {CH{tbl[r].div}};
      bus.load = tbl[r].load;
      @(posedge clk);
      #1;
      check($sformatf("tbl_row%0d", r),
            {12'd0, bus.q_rise[0], bus.q_fall[0], bus.sync[0], bus.running[0], bus.busy},
            {12'd0, tbl[r].exp});
    end

    // Random traffic on all channels against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        int r;
        if ($urandom_range(0, 7) == 0) bus.en[i] = ~bus.en[i];
        r = int'($urandom_range(0, 31));
        bus.div[i*DW +: DW] = (r == 1) ? 8'd255 : 8'(r % 7);
      end
      bus.load = ($urandom_range(0, 11) == 0);
      step($sformatf("rand_cyc%0d", c));
    end

    // N=1 on ch1 and N=4 on ch2 together, then an async reset mid-period.
    do_reset();
    bus.div  = {8'd0, 8'd4, 8'd1, 8'd0};
    bus.load = 1'b1;
    step("mix_load");
    bus.load = 1'b0;
    bus.en   = 4'b0110;
    for (int c = 0; c < 10; c++) step($sformatf("mix_cyc%0d", c));
    check("pre_reset_ch1_rise", {16'd0, bus.q_rise[1]}, 17'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), 17'd0);
    repeat (2) @(posedge clk);
    bus.en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("post_reset_state", dut_vec(), 17'd0);
    // Reset ratio must be the default N=2.
    bus.en = 4'b0001;
    for (int c = 0; c < 6; c++) step($sformatf("post_rst_cyc%0d", c));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
